// File: rtl/axil_sw_sequencer.sv
// axil_sw_sequencer: debounced switches queue AXI4-Lite writes (readback to led when AXIL_SEQ_READBACK_EN is defined)
module axil_sw_sequencer #(
  parameter int NUM_CH = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                      sysclk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         sw,
  output logic [NUM_CH-1:0]         led,
  output logic [ADDR_WIDTH-1:0]     m_awaddr,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [DATA_WIDTH-1:0]     m_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_wstrb,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic [1:0]                m_bresp,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  output logic [ADDR_WIDTH-1:0]     m_araddr,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  input  logic [DATA_WIDTH-1:0]     m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rvalid,
  output logic                      m_rready
);
  localparam int CHW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
`ifdef AXIL_SEQ_READBACK_EN
  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA} state_t;
`else
  typedef enum logic [1:0] {IDLE, WADDR, WRESP} state_t;
`endif
  state_t state_q, state_d;
  logic [NUM_CH-1:0] sync1_q, sync1_d, sync2_q, sync2_d, deb_q, deb_d, dly_q, dly_d;
  logic [NUM_CH-1:0] pend_q, pend_d, tgt_q, tgt_d, led_q, led_d, chg;
  logic [CW-1:0] cnt_q [NUM_CH], cnt_d [NUM_CH];
  logic [CHW-1:0] last_q, last_d, ch_q, ch_d, gnt;
  logic gnt_v, grant;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
`ifdef AXIL_SEQ_READBACK_EN
  logic arvalid_q, arvalid_d, rready_q, rready_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic unused;
  assign unused = ^m_rdata[DATA_WIDTH-1:1];
  assign m_arvalid = arvalid_q;
  assign m_rready = rready_q;
  assign m_araddr = araddr_q;
`else
  logic bit_q, bit_d;
  logic unused;
  assign unused = ^{m_arready, m_rdata, m_rresp, m_rvalid};
  assign m_arvalid = 1'b0;
  assign m_rready = 1'b0;
  assign m_araddr = '0;
`endif
  assign led = led_q;
  assign m_awaddr = awaddr_q;
  assign m_awvalid = awvalid_q;
  assign m_wdata = wdata_q;
  assign m_wstrb = wstrb_q;
  assign m_wvalid = wvalid_q;
  assign m_bready = bready_q;
  always_comb begin
    sync1_d = sw;
    sync2_d = sync1_q;
    deb_d = deb_q;
    dly_d = deb_q;
    chg = deb_q ^ dly_q;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = sync2_q[i] != deb_q[i] ? cnt_q[i] + CW'(1) : '0;
      if (sync2_q[i] != deb_q[i] && cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end
    end
    gnt_v = 1'b0;
    gnt = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (pend_q[(int'(last_q) + k) % NUM_CH]) begin
        gnt_v = 1'b1;
        gnt = CHW'((int'(last_q) + k) % NUM_CH);
      end
    end
    grant = state_q == IDLE && gnt_v;
    // a change landing with the grant re-arms pending with the fresh target
    pend_d = (pend_q & ~({NUM_CH{grant}} & (NUM_CH'(1) << gnt))) | chg;
    tgt_d = (tgt_q & ~chg) | (deb_q & chg);
    state_d = state_q;
    last_d = last_q;
    ch_d = ch_q;
    led_d = led_q;
    awvalid_d = awvalid_q;
    wvalid_d = wvalid_q;
    bready_d = bready_q;
    awaddr_d = awaddr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
`ifdef AXIL_SEQ_READBACK_EN
    arvalid_d = arvalid_q;
    rready_d = rready_q;
    araddr_d = araddr_q;
`else
    bit_d = bit_q;
`endif
    case (state_q)
      IDLE: if (grant) begin
        state_d = WADDR;
        last_d = gnt;
        ch_d = gnt;
        awvalid_d = 1'b1;
        wvalid_d = 1'b1;
        awaddr_d = BASE_ADDR + (ADDR_WIDTH'(gnt) << 2);
        wdata_d = DATA_WIDTH'(tgt_q[gnt]);
        wstrb_d = '1;
`ifndef AXIL_SEQ_READBACK_EN
        bit_d = tgt_q[gnt];
`endif
      end
      WADDR: begin
        awvalid_d = awvalid_q && !m_awready;
        wvalid_d = wvalid_q && !m_wready;
        if ((!awvalid_q || m_awready) && (!wvalid_q || m_wready)) begin
          state_d = WRESP;
          bready_d = 1'b1;
        end
      end
      WRESP: if (m_bvalid) begin
        bready_d = 1'b0;
`ifdef AXIL_SEQ_READBACK_EN
        state_d = m_bresp == 2'b00 ? RADDR : IDLE;
        arvalid_d = m_bresp == 2'b00;
        araddr_d = awaddr_q;
`else
        state_d = IDLE;
        if (m_bresp == 2'b00) led_d[ch_q] = bit_q;
`endif
      end
`ifdef AXIL_SEQ_READBACK_EN
      RADDR: if (m_arready) begin
        arvalid_d = 1'b0;
        rready_d = 1'b1;
        state_d = RDATA;
      end
      RDATA: if (m_rvalid) begin
        rready_d = 1'b0;
        state_d = IDLE;
        if (m_rresp == 2'b00) led_d[ch_q] = m_rdata[0];
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q <= IDLE;
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q <= '0;
      dly_q <= '0;
      pend_q <= '0;
      tgt_q <= '0;
      led_q <= '0;
      cnt_q <= '{default: '0};
      last_q <= CHW'(NUM_CH - 1);
      ch_q <= '0;
      awvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
      bready_q <= 1'b0;
      awaddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
`ifdef AXIL_SEQ_READBACK_EN
      arvalid_q <= 1'b0;
      rready_q <= 1'b0;
      araddr_q <= '0;
`else
      bit_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q <= deb_d;
      dly_q <= dly_d;
      pend_q <= pend_d;
      tgt_q <= tgt_d;
      led_q <= led_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      ch_q <= ch_d;
      awvalid_q <= awvalid_d;
      wvalid_q <= wvalid_d;
      bready_q <= bready_d;
      awaddr_q <= awaddr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
`ifdef AXIL_SEQ_READBACK_EN
      arvalid_q <= arvalid_d;
      rready_q <= rready_d;
      araddr_q <= araddr_d;
`else
      bit_q <= bit_d;
`endif
    end
  end
endmodule

// File: doc/axil_sw_sequencer.md
# axil_sw_sequencer

Parametrised switch-to-AXI4-Lite transaction sequencer sitting between the board switches/LEDs and the AXI4-Lite register slave in `top`. Each of NUM_CH switch inputs is synchronised and debounced. Every debounced level change queues one AXI4-Lite write of that level to the channel's register, optionally followed by a readback. The readback (or write-acknowledged value) drives the channel's LED. Multiple channels are served by a round-robin arbiter over a single AXI4-Lite master port.

## Interface
- NUM_CH, 4, number of switch/LED channels (1..16)
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data width (32 or 64)
- BASE_ADDR, 0, address of channel 0 register; channel i at BASE_ADDR + 4*i
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a new level (>=1)
- sysclk  in  1  system clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- sw  in  NUM_CH  asynchronous switch inputs
- led  out  NUM_CH  per-channel status
- m_awaddr/m_awvalid/m_awready  out/out/in  ADDR_WIDTH/1/1  write address channel
- m_wdata/m_wstrb/m_wvalid/m_wready  out/out/out/in  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel
- m_bresp/m_bvalid/m_bready  in/in/out  2/1/1  write response channel
- m_araddr/m_arvalid/m_arready  out/out/in  ADDR_WIDTH/1/1  read address channel
- m_rdata/m_rresp/m_rvalid/m_rready  in/in/in/out  DATA_WIDTH/2/1/1  read data channel

## Operation
- Per channel: 2-FF synchroniser, then debounce. A counter runs while the synced value differs from the debounced value and clears when they match. The debounced value takes the synced value when the counter reaches DEBOUNCE_CYCLES.
- A debounced change sets `pending[i]` and `target[i]` = new level on the next cycle.
- Arbiter (in IDLE only): grants the first pending channel searching from last_granted+1 with wrap. After reset, channel 0 has the highest priority. The grant clears `pending[i]` and latches ch and `target[i]` into the transaction registers.
- If a new debounced change lands in the same cycle as the grant, pending stays 1 with the new target (set wins). A later change of an in-flight channel re-queues it.
- FSM: IDLE -> WADDR (awvalid and wvalid asserted together; each deasserts independently after its handshake; leave when both have completed) -> WRESP (bready=1 until bvalid) -> RADDR (arvalid until arready) -> RDATA (rready=1 until rvalid) -> IDLE.
- Write: awaddr = BASE_ADDR + 4*ch; wdata = zero-extended target bit; wstrb all ones.
- Completion:
  - rresp==OKAY: led[ch] <= rdata[0].
  - rresp!=OKAY: led[ch] unchanged.
  - bresp!=OKAY: skip the read phase, led unchanged, WRESP -> IDLE.
- AXI rules: valid never depends on ready; address/data stable while valid is high; at most one outstanding transaction.

## Timing
- Reset values: led=0; all *valid, bready, rready = 0; awaddr/araddr/wdata/wstrb = 0; sync, debounced, pending, counters = 0; FSM=IDLE.
- Reset mid-transaction: all valids/readies low the cycle after rst is sampled; the transaction is abandoned and no LED update occurs.
- Switch edge to pending: 2 sync + DEBOUNCE_CYCLES + 1 cycles.
- Pending to awvalid: 1 cycle (grant in IDLE, awvalid registered).
- With an always-ready slave and 1-cycle responses: awvalid -> bvalid handshake -> arvalid -> rvalid -> led update. Each phase takes at least 1 cycle; led updates the cycle after the rvalid&rready handshake.
- Back-to-back: after RDATA, IDLE lasts exactly 1 cycle before the next grant.

## Configuration
- AXIL_SEQ_READBACK_EN defined: full flow as above, led from readback rdata[0].
- Undefined:
  - RADDR/RDATA states are removed; m_arvalid and m_rready are tied 0.
  - On bresp==OKAY, led[ch] <= target latched at grant.
  - On error, led is unchanged.
  - WRESP -> IDLE directly.

## Test plan
- Reset release, NUM_CH=4, sw=0 held 100 cycles -> no AXI valid asserted, led=0000.
- sw[0] 0->1 held 1000 ns, ideal slave, DEBOUNCE_CYCLES=16 -> one write addr 0x0 data 0x1, readback 1, led[0]=1. sw[0] -> 0 -> write data 0x0, led[0]=0.
- sw[0] glitch high for 8 cycles (< DEBOUNCE_CYCLES) -> no AXI activity, led unchanged.
- sw[3:0]=1111 in the same cycle -> writes issued in order ch0, ch1, ch2, ch3 to 0x0, 0x4, 0x8, 0xC; led=1111.
- Slave returns bresp=SLVERR for ch2 -> no read issued, led[2] unchanged, next pending channel served.
- rst asserted while awvalid=1 and awready held 0 -> awvalid=0 the next cycle, led=0, and a fresh edge after reset is processed normally.
